// File: rtl/uart_komut_cozucu.sv
// uart_komut_cozucu
// Parses ASCII set commands arriving from uart_rx and drives the clock/calendar core.
//   "T" HH MM SS CR   -> time load   (saat_yukle + saat/dakika/saniye_deger)
//   "D" DD MM YYYY CR -> date load   (tarih_yukle + gun/ay/yil_deger)
//   "P" / "R"         -> durdur / baslat pulse
// Every complete command is answered with 'K' (accepted) or 'E' (rejected) via uart_tx.
// Ports:
//   CLK, reset               clock, synchronous active-low reset
//   rx_data/rx_valid         received byte and its one-cycle strobe
//   rx_break                 line break: abandon the current frame
//   tx_busy, tx_en, tx_data  response handshake towards uart_tx
//   yanit_tasma              sticky: a response was dropped because one was still pending
module uart_komut_cozucu #(
    parameter int unsigned ZAMAN_ASIMI = 100_000_000,
    parameter int unsigned YIL_MIN     = 2000,
    parameter int unsigned YIL_MAX     = 4095
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_break,
    input  logic        tx_busy,
    output logic        tx_en,
    output logic [7:0]  tx_data,
    output logic        saat_yukle,
    output logic [4:0]  saat_deger,
    output logic [5:0]  dakika_deger,
    output logic [5:0]  saniye_deger,
    output logic        tarih_yukle,
    output logic [4:0]  gun_deger,
    output logic [3:0]  ay_deger,
    output logic [11:0] yil_deger,
    output logic        durdur,
    output logic        baslat,
    output logic        yanit_tasma
);
    localparam logic [2:0] BOSTA    = 3'd0;
    localparam logic [2:0] RAKAM_T  = 3'd1;
    localparam logic [2:0] RAKAM_D  = 3'd2;
    localparam logic [2:0] BEKLE_CR = 3'd3;
    localparam logic [2:0] ATLA     = 3'd4;
    localparam logic [2:0] DOGRULA  = 3'd5;
    localparam logic [2:0] CIKIS    = 3'd6;

    localparam int unsigned SW = (ZAMAN_ASIMI > 1) ? $clog2(ZAMAN_ASIMI) : 1;
    localparam logic [SW-1:0] SAYAC_SON = SW'(ZAMAN_ASIMI - 1);

    localparam logic [7:0] ACK = 8'h4B;
    localparam logic [7:0] NAK = 8'h45;

    logic [2:0]    r_durum;
    logic          r_tarih;     // 1: date frame, 0: time frame
    logic [2:0]    r_idx;
    logic          r_hata;
    logic [6:0]    r_a0, r_a1, r_a2;
    logic [13:0]   r_yil;
    logic [SW-1:0] r_sayac;

    logic          r_saat_yukle, r_tarih_yukle, r_durdur, r_baslat;
    logic [4:0]    r_saat, r_gun;
    logic [5:0]    r_dakika, r_saniye;
    logic [3:0]    r_ay;
    logic [11:0]   r_yil_cikis;

    logic          r_bekleyen, r_tasma;
    logic [7:0]    r_yanit;

    logic       w_rakam, w_cr, w_son_basamak, w_zaman_sayar, w_zaman_doldu;
    logic       w_saat_ok, w_tarih_ok, w_ack, w_yanit_yaz, w_gonder;
    logic [3:0] w_basamak;
    logic [7:0] w_yanit_veri;

    assign w_rakam       = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign w_cr          = (rx_data == 8'h0D);
    assign w_basamak     = rx_data[3:0];
    assign w_son_basamak = r_tarih ? (r_idx == 3'd7) : (r_idx == 3'd5);
    assign w_zaman_sayar = (r_durum == RAKAM_T) || (r_durum == RAKAM_D) ||
                           (r_durum == BEKLE_CR) || (r_durum == ATLA);
    assign w_zaman_doldu = w_zaman_sayar && !rx_valid && (r_sayac == SAYAC_SON);

    assign w_saat_ok  = (r_a0 <= 7'd23) && (r_a1 <= 7'd59) && (r_a2 <= 7'd59);
    assign w_tarih_ok = (r_a0 >= 7'd1) && (r_a0 <= 7'd31) && (r_a1 >= 7'd1) &&
                        (r_a1 <= 7'd12) && (r_yil >= 14'(YIL_MIN)) && (r_yil <= 14'(YIL_MAX));
    assign w_ack      = !r_hata && (r_tarih ? w_tarih_ok : w_saat_ok);

    // A response is produced by an accepted P/R byte or by the validation cycle.
    assign w_yanit_yaz  = !rx_break &&
                          (((r_durum == BOSTA) && rx_valid &&
                            ((rx_data == 8'h50) || (rx_data == 8'h52))) ||
                           (r_durum == DOGRULA));
    assign w_yanit_veri = ((r_durum == DOGRULA) && !w_ack) ? NAK : ACK;
    assign w_gonder     = r_bekleyen && !tx_busy;

    function automatic logic [6:0] katla7(input logic [6:0] a, input logic [3:0] d);
        return (a * 7'd10) + {3'b000, d};
    endfunction

    function automatic logic [13:0] katla14(input logic [13:0] a, input logic [3:0] d);
        return (a * 14'd10) + {10'd0, d};
    endfunction

    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_durum       <= BOSTA;
            r_tarih       <= 1'b0;
            r_idx         <= 3'd0;
            r_hata        <= 1'b0;
            r_a0          <= 7'd0;
            r_a1          <= 7'd0;
            r_a2          <= 7'd0;
            r_yil         <= 14'd0;
            r_sayac       <= '0;
            r_saat_yukle  <= 1'b0;
            r_tarih_yukle <= 1'b0;
            r_durdur      <= 1'b0;
            r_baslat      <= 1'b0;
            r_saat        <= 5'd0;
            r_dakika      <= 6'd0;
            r_saniye      <= 6'd0;
            r_gun         <= 5'd0;
            r_ay          <= 4'd0;
            r_yil_cikis   <= 12'd0;
        end else begin
            r_saat_yukle  <= 1'b0;
            r_tarih_yukle <= 1'b0;
            r_durdur      <= 1'b0;
            r_baslat      <= 1'b0;

            // Idle-gap counter: only meaningful inside a frame, restarts on every byte.
            if (w_zaman_sayar && !rx_valid) r_sayac <= r_sayac + 1'b1;
            else                            r_sayac <= '0;

            if (rx_break || w_zaman_doldu) begin
                r_durum <= BOSTA;
            end else begin
                case (r_durum)
                    BOSTA: begin
                        if (rx_valid) begin
                            r_idx  <= 3'd0;
                            r_hata <= 1'b0;
                            r_a0   <= 7'd0;
                            r_a1   <= 7'd0;
                            r_a2   <= 7'd0;
                            r_yil  <= 14'd0;
                            case (rx_data)
                                8'h54: begin r_tarih <= 1'b0; r_durum <= RAKAM_T; end
                                8'h44: begin r_tarih <= 1'b1; r_durum <= RAKAM_D; end
                                8'h50: begin r_durdur <= 1'b1; r_durum <= CIKIS; end
                                8'h52: begin r_baslat <= 1'b1; r_durum <= CIKIS; end
                                default: ;
                            endcase
                        end
                    end
                    RAKAM_T, RAKAM_D: begin
                        if (rx_valid) begin
                            if (w_rakam) begin
                                // idx[2:1] selects the field: 0 -> a0, 1 -> a1, else a2/year.
                                case (r_idx[2:1])
                                    2'd0:    r_a0 <= katla7(r_a0, w_basamak);
                                    2'd1:    r_a1 <= katla7(r_a1, w_basamak);
                                    default: begin
                                        if (r_tarih) r_yil <= katla14(r_yil, w_basamak);
                                        else         r_a2  <= katla7(r_a2, w_basamak);
                                    end
                                endcase
                                r_idx <= r_idx + 3'd1;
                                if (w_son_basamak) r_durum <= BEKLE_CR;
                            end else if (w_cr) begin
                                r_hata  <= 1'b1;
                                r_durum <= DOGRULA;
                            end else begin
                                r_durum <= ATLA;
                            end
                        end
                    end
                    BEKLE_CR: begin
                        if (rx_valid) r_durum <= w_cr ? DOGRULA : ATLA;
                    end
                    ATLA: begin
                        if (rx_valid && w_cr) begin
                            r_hata  <= 1'b1;
                            r_durum <= DOGRULA;
                        end
                    end
                    DOGRULA: begin
                        if (w_ack) begin
                            if (r_tarih) begin
                                r_gun         <= r_a0[4:0];
                                r_ay          <= r_a1[3:0];
                                r_yil_cikis   <= r_yil[11:0];
                                r_tarih_yukle <= 1'b1;
                            end else begin
                                r_saat        <= r_a0[4:0];
                                r_dakika      <= r_a1[5:0];
                                r_saniye      <= r_a2[5:0];
                                r_saat_yukle  <= 1'b1;
                            end
                        end
                        r_durum <= CIKIS;
                    end
                    CIKIS:   r_durum <= BOSTA;
                    default: r_durum <= BOSTA;
                endcase
            end
        end
    end

    // One-entry response buffer. An entry leaving this cycle frees the slot for a new one.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_bekleyen <= 1'b0;
            r_yanit    <= 8'h00;
            r_tasma    <= 1'b0;
        end else begin
            if (w_gonder) r_bekleyen <= 1'b0;
            if (w_yanit_yaz) begin
                if (r_bekleyen && !w_gonder) begin
                    r_tasma <= 1'b1;
                end else begin
                    r_bekleyen <= 1'b1;
                    r_yanit    <= w_yanit_veri;
                end
            end
        end
    end

    assign tx_en        = w_gonder;
    assign tx_data      = r_yanit;
    assign yanit_tasma  = r_tasma;
    assign saat_yukle   = r_saat_yukle;
    assign saat_deger   = r_saat;
    assign dakika_deger = r_dakika;
    assign saniye_deger = r_saniye;
    assign tarih_yukle  = r_tarih_yukle;
    assign gun_deger    = r_gun;
    assign ay_deger     = r_ay;
    assign yil_deger    = r_yil_cikis;
    assign durdur       = r_durdur;
    assign baslat       = r_baslat;

endmodule

// File: tb/tb_uart_komut_cozucu.sv
// tb_uart_komut_cozucu
// Directed bench for uart_komut_cozucu: sends command frames byte by byte, records strobes,
// pulses and transmitted response bytes, and compares them with hand-computed values.
module tb_uart_komut_cozucu;
    localparam int unsigned ZA = 40;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_break = 1'b0;
    logic        tx_busy = 1'b0;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic        saat_yukle, tarih_yukle, durdur, baslat, yanit_tasma;
    logic [4:0]  saat_deger, gun_deger;
    logic [5:0]  dakika_deger, saniye_deger;
    logic [3:0]  ay_deger;
    logic [11:0] yil_deger;

    uart_komut_cozucu #(
        .ZAMAN_ASIMI (ZA),
        .YIL_MIN     (2000),
        .YIL_MAX     (4095)
    ) dut (
        .CLK          (CLK),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_break     (rx_break),
        .tx_busy      (tx_busy),
        .tx_en        (tx_en),
        .tx_data      (tx_data),
        .saat_yukle   (saat_yukle),
        .saat_deger   (saat_deger),
        .dakika_deger (dakika_deger),
        .saniye_deger (saniye_deger),
        .tarih_yukle  (tarih_yukle),
        .gun_deger    (gun_deger),
        .ay_deger     (ay_deger),
        .yil_deger    (yil_deger),
        .durdur       (durdur),
        .baslat       (baslat),
        .yanit_tasma  (yanit_tasma)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_saat = 0, n_tarih = 0, n_durdur = 0, n_baslat = 0;
    int cr_cyc = 0, pr_cyc = 0, lat_yukle = -1, lat_pr = -1;
    logic [7:0] tx_q[$];

    // Observe on the falling edge, half a cycle away from the sampling edge.
    always @(negedge CLK) begin
        if (rx_valid && rx_data == 8'h0D) cr_cyc = cyc;
        if (rx_valid && (rx_data == 8'h50 || rx_data == 8'h52)) pr_cyc = cyc;
        if (saat_yukle)  begin n_saat++;  lat_yukle = cyc - cr_cyc; end
        if (tarih_yukle) begin n_tarih++; lat_yukle = cyc - cr_cyc; end
        if (durdur)      begin n_durdur++; lat_pr = cyc - pr_cyc; end
        if (baslat)      begin n_baslat++; lat_pr = cyc - pr_cyc; end
        if (tx_en) tx_q.push_back(tx_data);
    end

    int n_kontrol = 0, n_gecen = 0;

    task automatic kontrol(input string etiket, input int gozlenen, input int beklenen);
        n_kontrol++;
        if (gozlenen == beklenen) n_gecen++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                      etiket, gozlenen, gozlenen, beklenen, beklenen);
    endtask

    task automatic bosta(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic bayt_gonder(input logic [7:0] b);
        @(posedge CLK);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge CLK);
        #1;
        rx_valid = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
    endtask

    task automatic dizi_gonder(input string s);
        for (int i = 0; i < s.len(); i++) bayt_gonder(s[i]);
    endtask

    task automatic cerceve(input string govde);
        dizi_gonder(govde);
        bayt_gonder(8'h0D);
        bosta(12);
    endtask

    task automatic yanit_kontrol(input string etiket, input int adet, input logic [7:0] son);
        logic [7:0] gercek;
        gercek = (tx_q.size() > 0) ? tx_q[tx_q.size() - 1] : 8'h00;
        kontrol({etiket, "_tx_adet"}, tx_q.size(), adet);
        kontrol({etiket, "_tx_veri"}, gercek, son);
    endtask

    initial begin
        // Reset
        bosta(3);
        @(negedge CLK);
        kontrol("rst_tx_en", tx_en, 0);
        kontrol("rst_tx_data", tx_data, 0);
        kontrol("rst_strobes", {saat_yukle, tarih_yukle, durdur, baslat}, 0);
        kontrol("rst_saat", {saat_deger, dakika_deger, saniye_deger}, 0);
        kontrol("rst_tarih", {gun_deger, ay_deger, yil_deger}, 0);
        kontrol("rst_tasma", yanit_tasma, 0);
        reset = 1'b1;
        bosta(2);

        // Time load
        cerceve("T183045");
        kontrol("t1_adet", n_saat, 1);
        kontrol("t1_gecikme", lat_yukle, 2);
        kontrol("t1_saat", saat_deger, 18);
        kontrol("t1_dakika", dakika_deger, 30);
        kontrol("t1_saniye", saniye_deger, 45);
        yanit_kontrol("t1", 1, 8'h4B);

        // Date load, then an out-of-range day
        cerceve("D29022024");
        kontrol("d1_adet", n_tarih, 1);
        kontrol("d1_gecikme", lat_yukle, 2);
        kontrol("d1_deger", {gun_deger, ay_deger, yil_deger}, {5'd29, 4'd2, 12'd2024});
        yanit_kontrol("d1", 2, 8'h4B);
        cerceve("D32012024");
        kontrol("d2_adet", n_tarih, 1);
        kontrol("d2_deger", {gun_deger, ay_deger, yil_deger}, {5'd29, 4'd2, 12'd2024});
        yanit_kontrol("d2", 3, 8'h45);

        // Malformed and short time frames, then a zero time
        cerceve("T12a456");
        yanit_kontrol("t_harf", 4, 8'h45);
        cerceve("T1234");
        yanit_kontrol("t_kisa", 5, 8'h45);
        kontrol("t_hatali_adet", n_saat, 1);
        cerceve("T000000");
        kontrol("t0_adet", n_saat, 2);
        kontrol("t0_deger", {saat_deger, dakika_deger, saniye_deger}, 0);
        yanit_kontrol("t0", 6, 8'h4B);

        // Range boundaries
        cerceve("T235959");
        yanit_kontrol("t_ust", 7, 8'h4B);
        cerceve("T240000");
        yanit_kontrol("t_asim", 8, 8'h45);
        kontrol("t_asim_adet", n_saat, 3);
        kontrol("t_asim_deger", {saat_deger, dakika_deger, saniye_deger},
                {5'd23, 6'd59, 6'd59});
        cerceve("D31124095");
        yanit_kontrol("d_ust", 9, 8'h4B);
        kontrol("d_ust_deger", {gun_deger, ay_deger, yil_deger}, {5'd31, 4'd12, 12'd4095});
        cerceve("D01011999");
        yanit_kontrol("d_alt", 10, 8'h45);
        kontrol("d_alt_adet", n_tarih, 2);

        // Pause/run while the transmitter is busy: second response is dropped
        tx_busy = 1'b1;
        bayt_gonder(8'h50);
        kontrol("p_gecikme", lat_pr, 1);
        bayt_gonder(8'h52);
        kontrol("r_gecikme", lat_pr, 1);
        bosta(5);
        kontrol("pr_durdur", n_durdur, 1);
        kontrol("pr_baslat", n_baslat, 1);
        kontrol("pr_tx_bekle", tx_q.size(), 10);
        kontrol("pr_tasma", yanit_tasma, 1);
        tx_busy = 1'b0;
        bosta(5);
        yanit_kontrol("pr", 11, 8'h4B);

        // Inter-byte timeout abandons the fragment silently
        dizi_gonder("T18");
        bosta(ZA + 1);
        kontrol("za_sessiz", tx_q.size(), 11);
        cerceve("T010203");
        kontrol("za_adet", n_saat, 4);
        kontrol("za_deger", {saat_deger, dakika_deger, saniye_deger}, {5'd1, 6'd2, 6'd3});
        yanit_kontrol("za", 12, 8'h4B);

        // Reset in the middle of a frame
        dizi_gonder("T12");
        reset = 1'b0;
        bosta(3);
        reset = 1'b1;
        cerceve("3045");
        kontrol("rst_orta_adet", n_saat, 4);
        kontrol("rst_orta_deger", {saat_deger, dakika_deger, saniye_deger}, 0);
        kontrol("rst_orta_tx", tx_q.size(), 12);
        kontrol("rst_orta_tasma", yanit_tasma, 0);

        // Line break after a partial date keeps the previous date
        cerceve("D01012030");
        kontrol("brk_once_adet", n_tarih, 3);
        yanit_kontrol("brk_once", 13, 8'h4B);
        dizi_gonder("D3007");
        @(posedge CLK);
        #1;
        rx_break = 1'b1;
        @(posedge CLK);
        #1;
        rx_break = 1'b0;
        cerceve("2024");
        kontrol("brk_adet", n_tarih, 3);
        kontrol("brk_deger", {gun_deger, ay_deger, yil_deger}, {5'd1, 4'd1, 12'd2030});
        kontrol("brk_tx", tx_q.size(), 13);

        $display("%0d/%0d checks passed", n_gecen, n_kontrol);
        $finish;
    end
endmodule

// File: doc/uart_komut_cozucu.md
Name: uart_komut_cozucu

Overview:
Sits directly upstream of the clock/calendar core. Consumes bytes from uart_rx and parses ASCII set commands. Emits validated time/date load strobes and run/pause pulses to the core. Returns a one-byte ACK ('K', 8'h4B) or NAK ('E', 8'h45) through the uart_tx handshake.

Parameters:
ZAMAN_ASIMI, 100_000_000, idle cycles allowed between bytes inside a frame before a silent abort (1 s at 100 MHz).
YIL_MIN, 2000, lowest accepted year.
YIL_MAX, 4095, highest accepted year (12-bit limit).

Ports:
CLK  input  1  system clock, 100 MHz
reset  input  1  synchronous, active-low reset
rx_data  input  8  byte from uart_rx
rx_valid  input  1  one-cycle strobe; rx_data is valid in that cycle
rx_break  input  1  line break detected
tx_busy  input  1  uart_tx busy
tx_en  output  1  one-cycle send request
tx_data  output  8  response byte ('K' or 'E')
saat_yukle  output  1  one-cycle time-load strobe
saat_deger  output  5  hour, 0..23
dakika_deger  output  6  minute, 0..59
saniye_deger  output  6  second, 0..59
tarih_yukle  output  1  one-cycle date-load strobe
gun_deger  output  5  day, 1..31
ay_deger  output  4  month, 1..12
yil_deger  output  12  year
durdur  output  1  one-cycle pause pulse
baslat  output  1  one-cycle run pulse
yanit_tasma  output  1  sticky flag: a response was dropped

Behaviour:
- Reset (reset==0 at a CLK edge):
  - All strobes and pulses are 0; tx_en=0; tx_data=0; yanit_tasma=0.
  - Value outputs return to 0; the FSM returns to BOSTA; the pending response and the timeout counter are cleared.
- Frame formats (uppercase only):
  - "T" HH MM SS CR: exactly 6 ASCII digits.
  - "D" DD MM YYYY CR: exactly 8 ASCII digits.
  - "P": pause. "R": run. Both single-byte, no CR.
- FSM states: BOSTA, RAKAM_T, RAKAM_D, BEKLE_CR, ATLA, DOGRULA, and a one-cycle output state CIKIS.
- BOSTA:
  - 'T' goes to RAKAM_T; 'D' goes to RAKAM_D. The digit index is reset to 0.
  - 'P' or 'R' goes to CIKIS with ACK.
  - Any other byte, including CR and LF, is ignored silently.
- RAKAM_x:
  - Each byte 0x30..0x39 is folded into the current field as field*10+digit. The 2-digit fields use 7-bit accumulators; the year uses a 14-bit accumulator.
  - After the last digit, go to BEKLE_CR.
  - A non-digit byte goes to ATLA; an early CR goes directly to DOGRULA with the error flag set.
- BEKLE_CR: CR goes to DOGRULA. Any other byte goes to ATLA (overlong frame).
- ATLA: discards bytes until CR, then goes to DOGRULA with the error flag set.
- DOGRULA (one cycle) checks ranges:
  - Hour ≤23, minute ≤59, second ≤59.
  - Day 1..31, month 1..12, YIL_MIN ≤ year ≤ YIL_MAX.
  - Day/month consistency is not checked; the core handles that.
  - Any violation or the error flag produces NAK; otherwise ACK. Then go to CIKIS.
- CIKIS, on ACK:
  - For T: the value outputs update and saat_yukle=1 for exactly 1 cycle.
  - For D: the date outputs update and tarih_yukle=1.
  - For P/R: durdur or baslat =1 for 1 cycle.
  - On NAK, no strobe fires and no value output changes.
  - Then go to BOSTA.
- Latency:
  - A terminating CR accepted at cycle N gives its strobe at N+2.
  - A P/R byte at cycle N gives its pulse at N+1.
  - Value outputs hold their last accepted values indefinitely.
- Response path:
  - One-entry pending register. It is loaded in the same cycle as the strobe, or in the NAK decision cycle.
  - tx_en=1 for one cycle, with tx_data set, at the first cycle where the entry is pending and tx_busy==0. The entry clears in that same cycle.
  - If a new response arrives while one is still pending, the older entry is kept, the new one is dropped, and yanit_tasma is set. yanit_tasma clears only on reset.
- Timeout:
  - The counter runs in RAKAM_x, BEKLE_CR and ATLA, and reloads on every rx_valid.
  - At ZAMAN_ASIMI cycles, go to BOSTA with no response and no strobe.
- rx_break:
  - In any state, go to BOSTA with no response. A pending response is kept.
  - If rx_break and rx_valid occur in the same cycle, the break wins and the byte is dropped.
- rx_valid is ignored during DOGRULA and CIKIS; the byte is lost.
- Reset mid-frame discards the partial frame with no output.

Test Plan:
- Send "T183045\r" -> saat_yukle a single pulse at N+2 with saat_deger=18, dakika_deger=30, saniye_deger=45; then tx_en with tx_data=8'h4B.
- Send "D29022024\r" then "D32012024\r" -> first: tarih_yukle with 29/2/2024 and 'K'. Second: no strobe, values stay 29/2/2024, 'E'.
- Send "T12a456\r" and "T1234\r" -> both give 'E' only. A following "T000000\r" loads 0:0:0 with 'K'.
- Hold tx_busy=1 and send "P" then "R" -> durdur and baslat each pulse once. One 'K' is sent after tx_busy falls; yanit_tasma=1.
- Send "T18", then stay idle for ZAMAN_ASIMI+1 cycles, then send "T010203\r" -> no response from the first fragment; the second loads 1:2:3 with 'K'.
- Assert reset low mid-frame, or assert rx_break after "D3007" -> no strobe and no tx_en; the outputs keep their reset or previous values.
